// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - instruction fetch stage: PC, imem req/ack reads, IR valid/ready, branch redirect (optional FETCH_STATS_EN stall counter)
module instr_fetch_unit #(
  parameter int                 ADDR_W   = 16,
  parameter int                 INSTR_W  = 16,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter int                 PC_INC   = 1
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               ir_valid,
  input  logic               ir_ready,
  output logic [INSTR_W-1:0] ir,
  output logic [ADDR_W-1:0]  ir_pc,
  input  logic               br_taken,
  input  logic [ADDR_W-1:0]  br_target,
  input  logic               halt
`ifdef FETCH_STATS_EN
  ,
  output logic [15:0]        stall_cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD} state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               req_q, req_d;
  logic               ir_valid_q, ir_valid_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [ADDR_W-1:0]  ir_pc_q, ir_pc_d;
  logic               squash_q, squash_d;

  // Next-state logic; a redirect always wins over the increment and the IR handshake.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    addr_d     = addr_q;
    ir_valid_d = ir_valid_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    squash_d   = squash_q;
    case (state_q)
      S_IDLE: begin
        if (br_taken) pc_d = br_target;
        if (!halt) state_d = S_REQ;
        addr_d = pc_d;
      end
      S_REQ: begin
        if (imem_ack) begin
          // Any ack closes the outstanding transaction, so a pending squash is consumed here.
          squash_d = 1'b0;
          if (br_taken) begin
            pc_d = br_target;
          end else if (!squash_q) begin
            ir_d       = imem_rdata;
            ir_pc_d    = pc_q;
            ir_valid_d = 1'b1;
            pc_d       = pc_q + ADDR_W'(PC_INC);
            state_d    = S_HOLD;
          end
          addr_d = pc_d;
        end else if (br_taken) begin
          // The address must stay put until the memory answers; the reply is dropped later.
          pc_d     = br_target;
          squash_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (br_taken) begin
          pc_d       = br_target;
          ir_valid_d = 1'b0;
          state_d    = S_REQ;
          addr_d     = pc_d;
        end else if (ir_ready) begin
          ir_valid_d = 1'b0;
          state_d    = halt ? S_IDLE : S_REQ;
          addr_d     = pc_d;
        end
      end
      default: state_d = S_IDLE;
    endcase
    req_d = (state_d == S_REQ);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      addr_q     <= RESET_PC;
      req_q      <= 1'b0;
      ir_valid_q <= 1'b0;
      ir_q       <= '0;
      ir_pc_q    <= '0;
      squash_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      addr_q     <= addr_d;
      req_q      <= req_d;
      ir_valid_q <= ir_valid_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      squash_q   <= squash_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign ir_valid  = ir_valid_q;
  assign ir        = ir_q;
  assign ir_pc     = ir_pc_q;

`ifdef FETCH_STATS_EN
  logic [15:0] stall_q;

  // Saturating count of cycles spent waiting on the memory.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (state_q == S_REQ && !imem_ack && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule
